// File: rtl/mapa_memoria_pkg.sv
// Shared memory-map definitions: region bases, one-hot device codes (also used by the
// read-data return mux) and the decoder FSM state type.
package mapa_memoria_pkg;

  localparam int unsigned NumDisp = 7;

  // Region bases; UART regions are identified by address bits [31:4]
  localparam logic [31:0] BASE_RAM    = 32'h1000_0000;
  localparam logic [31:0] DIR_SW      = 32'h2000_0000;
  localparam logic [31:0] DIR_LED     = 32'h2000_0004;
  localparam logic [31:0] DIR_7SEG    = 32'h2000_0008;
  localparam logic [27:0] PREF_UART_A = 28'h200_0001;
  localparam logic [27:0] PREF_UART_B = 28'h200_0002;
  localparam logic [27:0] PREF_UART_C = 28'h200_0003;

  // One-hot device codes, bit 0 = RAM
  localparam logic [NumDisp-1:0] DISP_NINGUNO = 7'b0000000;
  localparam logic [NumDisp-1:0] DISP_RAM     = 7'b0000001;
  localparam logic [NumDisp-1:0] DISP_SW      = 7'b0000010;
  localparam logic [NumDisp-1:0] DISP_LED     = 7'b0000100;
  localparam logic [NumDisp-1:0] DISP_7SEG    = 7'b0001000;
  localparam logic [NumDisp-1:0] DISP_UART_A  = 7'b0010000;
  localparam logic [NumDisp-1:0] DISP_UART_B  = 7'b0100000;
  localparam logic [NumDisp-1:0] DISP_UART_C  = 7'b1000000;
  localparam logic [NumDisp-1:0] DISP_UARTS   = DISP_UART_A | DISP_UART_B | DISP_UART_C;

  typedef enum logic [1:0] {
    StIdle,
    StEspera,
    StResp
  } estado_t;

  // Base-match mask for a power-of-two region of tam bytes
  function automatic logic [31:0] mascara_region(input int unsigned tam);
    return ~(32'(tam) - 32'd1);
  endfunction

endpackage

// File: rtl/decodificador_direcciones_if.sv
// Load/store bus between the CPU port (master) and the address decoder (slave).
interface decodificador_direcciones_if;
  import mapa_memoria_pkg::*;

  logic               req;
  logic               we;
  logic [31:0]        dir;
  logic               listo;
  logic               ocupado;
  logic [NumDisp-1:0] we_dispositivo;
  logic [NumDisp-1:0] sel_dispositivo;
  logic [11:0]        offset;
  logic               error;
  logic [7:0]         cuenta_errores;

  modport master (
    output req, we, dir,
    input  listo, ocupado, we_dispositivo, sel_dispositivo, offset, error, cuenta_errores
  );

  modport slave (
    input  req, we, dir,
    output listo, ocupado, we_dispositivo, sel_dispositivo, offset, error, cuenta_errores
  );

endinterface

// File: rtl/decodificador_region.sv
// Combinational address-to-device decode: one-hot device and offset within its region.
// Unmapped addresses give an all-zero device and zero offset.
module decodificador_region
  import mapa_memoria_pkg::*;
#(
  parameter int unsigned TAM_RAM = 4096
) (
  input  logic [31:0]        dir_i,
  output logic [NumDisp-1:0] disp_o,
  output logic [11:0]        offset_o
);

  localparam logic [31:0] MascaraRam = mascara_region(TAM_RAM);
  localparam logic [11:0] MascaraOff = 12'(TAM_RAM - 1);

  // Priority chain is safe: the regions are disjoint
  always_comb begin
    disp_o   = DISP_NINGUNO;
    offset_o = '0;
    if ((dir_i & MascaraRam) == BASE_RAM) begin
      disp_o   = DISP_RAM;
      offset_o = dir_i[11:0] & MascaraOff;
    end else if (dir_i == DIR_SW) begin
      disp_o = DISP_SW;
    end else if (dir_i == DIR_LED) begin
      disp_o = DISP_LED;
    end else if (dir_i == DIR_7SEG) begin
      disp_o = DISP_7SEG;
    end else if (dir_i[31:4] == PREF_UART_A) begin
      disp_o   = DISP_UART_A;
      offset_o = {8'h00, dir_i[3:0]};
    end else if (dir_i[31:4] == PREF_UART_B) begin
      disp_o   = DISP_UART_B;
      offset_o = {8'h00, dir_i[3:0]};
    end else if (dir_i[31:4] == PREF_UART_C) begin
      disp_o   = DISP_UART_C;
      offset_o = {8'h00, dir_i[3:0]};
    end
  end

endmodule

// File: rtl/decodificador_direcciones.sv
// Load/store address decoder: one-hot write strobes, registered read select for the read
// mux, and wait states for UART loads. Optional macro DECOD_ERROR_EN adds a sticky
// unmapped-access flag and a saturating unmapped-access counter.
module decodificador_direcciones
  import mapa_memoria_pkg::*;
#(
  parameter int unsigned LAT_UART = 2,
  parameter int unsigned TAM_RAM  = 4096
) (
  input logic                        clk_i,
  input logic                        rst_i,
  decodificador_direcciones_if.slave bus_io
);

  localparam logic [2:0] CuentaIni = 3'(LAT_UART - 1);

  logic [NumDisp-1:0] disp_dec;
  logic [11:0]        offset_dec;
  logic               es_uart;

  decodificador_region #(
    .TAM_RAM(TAM_RAM)
  ) u_region (
    .dir_i   (bus_io.dir),
    .disp_o  (disp_dec),
    .offset_o(offset_dec)
  );

  assign es_uart = |(disp_dec & DISP_UARTS);

  estado_t            estado_q;
  logic [2:0]         cuenta_q;
  logic               listo_q;
  logic               ocupado_q;
  logic [NumDisp-1:0] we_disp_q;
  logic [NumDisp-1:0] sel_disp_q;
  logic [11:0]        offset_q;

  // Access FSM with registered outputs; every output is set on entry to the state that shows it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      estado_q   <= StIdle;
      cuenta_q   <= '0;
      listo_q    <= 1'b0;
      ocupado_q  <= 1'b0;
      we_disp_q  <= '0;
      sel_disp_q <= '0;
      offset_q   <= '0;
    end else begin
      unique case (estado_q)
        StIdle: begin
          if (bus_io.req) begin
            ocupado_q <= 1'b1;
            offset_q  <= offset_dec;
            if (bus_io.we) begin
              estado_q  <= StResp;
              listo_q   <= 1'b1;
              we_disp_q <= disp_dec;
            end else begin
              sel_disp_q <= disp_dec;
              // With a single-cycle UART latency the wait state is skipped entirely
              if (es_uart && (LAT_UART > 1)) begin
                estado_q <= StEspera;
                cuenta_q <= CuentaIni;
              end else begin
                estado_q <= StResp;
                listo_q  <= 1'b1;
              end
            end
          end
        end
        StEspera: begin
          cuenta_q <= cuenta_q - 3'd1;
          if (cuenta_q == 3'd1) begin
            estado_q <= StResp;
            listo_q  <= 1'b1;
          end
        end
        StResp: begin
          estado_q   <= StIdle;
          listo_q    <= 1'b0;
          ocupado_q  <= 1'b0;
          we_disp_q  <= '0;
          sel_disp_q <= '0;
          offset_q   <= '0;
        end
        default: estado_q <= StIdle;
      endcase
    end
  end

  assign bus_io.listo           = listo_q;
  assign bus_io.ocupado         = ocupado_q;
  assign bus_io.we_dispositivo  = we_disp_q;
  assign bus_io.sel_dispositivo = sel_disp_q;
  assign bus_io.offset          = offset_q;

`ifdef DECOD_ERROR_EN
  logic       acepta_no_mapeado;
  logic       error_q;
  logic [7:0] cuenta_err_q;

  assign acepta_no_mapeado = (estado_q == StIdle) && bus_io.req && (disp_dec == DISP_NINGUNO);

  // Sticky unmapped flag and saturating count, updated at acceptance
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      error_q      <= 1'b0;
      cuenta_err_q <= '0;
    end else if (acepta_no_mapeado) begin
      error_q <= 1'b1;
      if (cuenta_err_q != 8'hFF) begin
        cuenta_err_q <= cuenta_err_q + 8'd1;
      end
    end
  end

  assign bus_io.error          = error_q;
  assign bus_io.cuenta_errores = cuenta_err_q;
`else
  assign bus_io.error          = 1'b0;
  assign bus_io.cuenta_errores = '0;
`endif

endmodule

// File: tb/tb_decodificador_direcciones.sv
// Self-checking bench for decodificador_direcciones: directed cases with literal expectations
// plus randomized traffic compared every cycle against a transaction-level model.
module tb_decodificador_direcciones;

  localparam int unsigned LAT = 3;
  localparam int unsigned TAM = 4096;
`ifdef DECOD_ERROR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decodificador_direcciones_if bus ();

  decodificador_direcciones #(
    .LAT_UART(LAT),
    .TAM_RAM (TAM)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Address map computed directly from region ranges
  function automatic logic [6:0] exp_disp(input logic [31:0] d);
    if (d >= 32'h1000_0000 && d < 32'h1000_0000 + TAM) return 7'b0000001;
    if (d == 32'h2000_0000) return 7'b0000010;
    if (d == 32'h2000_0004) return 7'b0000100;
    if (d == 32'h2000_0008) return 7'b0001000;
    if (d >= 32'h2000_0010 && d <= 32'h2000_001F) return 7'b0010000;
    if (d >= 32'h2000_0020 && d <= 32'h2000_002F) return 7'b0100000;
    if (d >= 32'h2000_0030 && d <= 32'h2000_003F) return 7'b1000000;
    return 7'b0000000;
  endfunction

  function automatic logic [11:0] exp_off(input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0;
    if (d >= 32'h1000_0000 && d < 32'h1000_0000 + TAM) r = d - 32'h1000_0000;
    else if (d >= 32'h2000_0010 && d <= 32'h2000_003F) r = d - (d & 32'hFFFF_FFF0);
    return r[11:0];
  endfunction

  // Model: m_t counts cycles since acceptance; the access lasts m_l cycles, listo on the last
  bit         m_act = 1'b0;
  int         m_t = 0;
  int         m_l = 1;
  logic [6:0] m_disp = '0;
  bit         m_we = 1'b0;
  logic [11:0] m_off = '0;
  bit         m_err = 1'b0;
  int         m_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_act <= 1'b0;
      m_t   <= 0;
      m_err <= 1'b0;
      m_cnt <= 0;
    end else if (m_act) begin
      if (m_t == m_l) m_act <= 1'b0;
      else m_t <= m_t + 1;
    end else if (bus.req) begin
      m_act  <= 1'b1;
      m_t    <= 1;
      m_disp <= exp_disp(bus.dir);
      m_we   <= bus.we;
      m_off  <= exp_off(bus.dir);
      m_l    <= (!bus.we && (exp_disp(bus.dir) & 7'b1110000) != 7'b0) ? int'(LAT) : 1;
      if (exp_disp(bus.dir) == 7'b0) begin
        m_err <= 1'b1;
        m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_listo", 32'(bus.listo), 32'(m_act && m_t == m_l));
      chk("m_ocupado", 32'(bus.ocupado), 32'(m_act));
      chk("m_sel", 32'(bus.sel_dispositivo), (m_act && !m_we) ? 32'(m_disp) : 32'h0);
      chk("m_we", 32'(bus.we_dispositivo), (m_act && m_we && m_t == m_l) ? 32'(m_disp) : 32'h0);
      if (m_act) chk("m_offset", 32'(bus.offset), 32'(m_off));
      chk("m_error", 32'(bus.error), ErrEn ? 32'(m_err) : 32'h0);
      chk("m_cuenta", 32'(bus.cuenta_errores), ErrEn ? 32'(m_cnt) : 32'h0);
    end
  end

  // Called at a negedge; request is sampled by the next posedge, returns one negedge later
  task automatic pulso(input bit we, input logic [31:0] d);
    bus.req = 1'b1;
    bus.we  = we;
    bus.dir = d;
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  function automatic logic [31:0] rand_dir();
    case ($urandom_range(0, 9))
      0, 1:    return 32'h1000_0000 + ($urandom % TAM);
      2:       return 32'h2000_0000;
      3:       return 32'h2000_0004;
      4:       return 32'h2000_0008;
      5:       return 32'h2000_0010 + ($urandom % 16);
      6:       return 32'h2000_0020 + ($urandom % 16);
      7:       return 32'h2000_0030 + ($urandom % 16);
      8:       return 32'h2000_0000 + ($urandom % 80);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] dirs [7];
  int unsigned prev_cyc;

  initial begin
    rst     = 1'b1;
    bus.req = 1'b0;
    bus.we  = 1'b0;
    bus.dir = '0;
    dirs = '{32'h1000_0000, 32'h2000_0000, 32'h2000_0004, 32'h2000_0008,
             32'h2000_0010, 32'h2000_0020, 32'h2000_0030};
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_listo", 32'(bus.listo), 32'h0);
    chk("rst_ocupado", 32'(bus.ocupado), 32'h0);
    chk("rst_we", 32'(bus.we_dispositivo), 32'h0);
    chk("rst_sel", 32'(bus.sel_dispositivo), 32'h0);
    chk("rst_offset", 32'(bus.offset), 32'h0);
    chk("rst_cuenta", 32'(bus.cuenta_errores), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Store to LED
    pulso(1'b1, 32'h2000_0004);
    chk("led_we", 32'(bus.we_dispositivo), 32'h04);
    chk("led_listo", 32'(bus.listo), 32'h1);
    chk("led_sel", 32'(bus.sel_dispositivo), 32'h0);
    @(negedge clk);
    chk("led_we_off", 32'(bus.we_dispositivo), 32'h0);
    chk("led_ocupado_off", 32'(bus.ocupado), 32'h0);

    // Load from RAM
    pulso(1'b0, 32'h1000_0010);
    chk("ram_sel", 32'(bus.sel_dispositivo), 32'h01);
    chk("ram_offset", 32'(bus.offset), 32'h010);
    chk("ram_listo", 32'(bus.listo), 32'h1);
    @(negedge clk);

    // UART B load, LAT=3, with a dropped request at N+2
    pulso(1'b0, 32'h2000_0024);
    chk("uartb_sel1", 32'(bus.sel_dispositivo), 32'h20);
    chk("uartb_listo1", 32'(bus.listo), 32'h0);
    @(negedge clk);
    chk("uartb_sel2", 32'(bus.sel_dispositivo), 32'h20);
    chk("uartb_listo2", 32'(bus.listo), 32'h0);
    bus.req = 1'b1;
    bus.we  = 1'b1;
    bus.dir = 32'h2000_0004;
    @(negedge clk);
    bus.req = 1'b0;
    chk("uartb_sel3", 32'(bus.sel_dispositivo), 32'h20);
    chk("uartb_listo3", 32'(bus.listo), 32'h1);
    chk("uartb_offset", 32'(bus.offset), 32'h4);
    @(negedge clk);
    chk("uartb_drop_ocupado", 32'(bus.ocupado), 32'h0);
    chk("uartb_drop_we", 32'(bus.we_dispositivo), 32'h0);
    chk("uartb_sel_off", 32'(bus.sel_dispositivo), 32'h0);

    // Unmapped load
    pulso(1'b0, 32'h3000_0000);
    chk("unm_sel", 32'(bus.sel_dispositivo), 32'h0);
    chk("unm_listo", 32'(bus.listo), 32'h1);
    chk("unm_we", 32'(bus.we_dispositivo), 32'h0);
    chk("unm_error", 32'(bus.error), ErrEn ? 32'h1 : 32'h0);
    chk("unm_cuenta", 32'(bus.cuenta_errores), ErrEn ? 32'h1 : 32'h0);
    @(negedge clk);

    // Reset in the middle of a UART A load
    pulso(1'b0, 32'h2000_0010);
    @(negedge clk);
    chk("rstmid_listo_pre", 32'(bus.listo), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_listo", 32'(bus.listo), 32'h0);
    chk("rstmid_ocupado", 32'(bus.ocupado), 32'h0);
    chk("rstmid_sel", 32'(bus.sel_dispositivo), 32'h0);
    chk("rstmid_offset", 32'(bus.offset), 32'h0);
    @(negedge clk);
    chk("rstmid_no_listo", 32'(bus.listo), 32'h0);
    pulso(1'b1, 32'h1000_0100);
    chk("rstmid_new_listo", 32'(bus.listo), 32'h1);
    chk("rstmid_new_we", 32'(bus.we_dispositivo), 32'h01);
    @(negedge clk);

    // Back-to-back stores to every region
    prev_cyc = 0;
    for (int i = 0; i < 7; i++) begin
      pulso(1'b1, dirs[i]);
      chk("b2b_we", 32'(bus.we_dispositivo), 32'h1 << i);
      if (i > 0) chk("b2b_gap", cyc - prev_cyc, 32'd2);
      prev_cyc = cyc;
      @(negedge clk);
    end

    // Counter saturation
    repeat (300) begin
      pulso(1'($urandom), 32'h4000_0000 | ($urandom & 32'hFFFF));
      @(negedge clk);
    end
    chk("sat_cuenta", 32'(bus.cuenta_errores), ErrEn ? 32'd255 : 32'h0);
    chk("sat_error", 32'(bus.error), ErrEn ? 32'h1 : 32'h0);

    // Random traffic, including requests while busy and occasional resets
    repeat (3000) begin
      bus.req = ($urandom % 3) == 0;
      bus.we  = 1'($urandom);
      bus.dir = rand_dir();
      rst     = ($urandom % 200) == 0;
      @(negedge clk);
    end
    bus.req = 1'b0;
    rst     = 1'b0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
